input_port_ctrl: RTL and testbench
==================================

Name: input_port_ctrl

Overview:
- Bus-side responder for the board's input devices: buttons and switches. It is the read counterpart of the 7-segment/LED write path.
- Synchronizes and debounces the 24 switches and 5 buttons, and captures button-press events into sticky flags.
- Exposes level and event registers to the CPU through the bridge's peripheral read/write interface.
- Sits between the board pins and the bridge, replacing the direct zero-extended pin feed.

Parameters:
TICK_CYCLES, 50000, clk cycles between debounce sample ticks (min 2)
DB_SAMPLES, 4, consecutive equal samples required to accept a new level (2..8)

Ports:
clk  in  1  peripheral clock (cpu_clk)
rst_n  in  1  asynchronous reset, active-low
switches  in  24  raw switch pins, asynchronous
button  in  5  raw button pins, asynchronous, high = pressed
addr  in  12  word offset from bridge; bits [3:2] decoded, others ignored
wen  in  1  write strobe, one cycle per store
wdata  in  32  store data
rdata  out  32  read data, combinational from addr

Behaviour:
Reset:
- All sync flops, sample shift regs, debounced state, event flags and prescaler clear to 0, asynchronously on rst_n low.
- rdata = 0 while held in reset.
- Reset mid-debounce discards all partial history.

Synchronizer:
- 2-flop synchronizer per input bit (29 bits).
- A raw change reaches the sync output 2 clk edges later.

Prescaler and tick:
- cnt counts 0..TICK_CYCLES-1 and wraps.
- tick is asserted for one cycle when cnt == TICK_CYCLES-1.
- First tick occurs on the TICK_CYCLES-th edge after reset release.

Debounce, per bit:
- On each tick, shift the synced value into a DB_SAMPLES-deep history.
- If all DB_SAMPLES entries (including the current sample) are equal and differ from the stable value, stable updates on that same edge.
- Glitches shorter than DB_SAMPLES ticks are never accepted.

Button events:
- btn_evt[i] sets on the cycle stable_btn[i] goes 0->1.
- Release does not set an event.
- Flags are sticky until cleared.

Register map, indexed by addr[3:2]:
0 SW: rdata = {8'b0, stable_sw}. Writes ignored.
1 BTN: rdata = {27'b0, stable_btn}. Writes ignored.
2 EVT: rdata = {27'b0, btn_evt}. Write-1-to-clear on wdata[4:0] when wen=1.
3 reserved: reads 0, writes ignored (without INPUT_IRQ_EN).

Simultaneous events:
- If an event sets and a W1C clears the same bit in the same cycle, set wins and the flag stays 1.
- A W1C with wdata bit = 0 leaves that flag untouched.
- rdata reflects register contents before the clock edge (read-during-write returns the old value).

Optional Feature:
INPUT_IRQ_EN
- Defined:
  - Adds port irq (out, 1) and register 3 MASK (5 bits, reset 0, read/write via wdata[4:0]).
  - irq is registered: irq <= |(btn_evt & mask). It asserts 1 cycle after the flag or mask condition is true, and deasserts 1 cycle after the clear.
  - irq resets to 0.
- Undefined:
  - No irq port and no mask flops.
  - Register 3 reads 0 and ignores writes.

Test Plan (TICK_CYCLES=4, DB_SAMPLES=3 unless stated):
1. Reset: hold rst_n=0 with switches=24'hFFFFFF -> rdata=0 for all addr. After release, SW stays 0 until 3 ticks sample 1, then SW reads 32'h00FFFFFF.
2. Button press: button=5'b00100 held stable -> BTN reads 32'h4 and EVT reads 32'h4. Release -> BTN=0, EVT still 32'h4.
3. Glitch rejection: button[0] high for exactly 2 ticks, then low -> BTN and EVT remain 0 throughout.
4. W1C:
   - With EVT=5'b10101, write 32'h00000005 to addr 0x008 -> EVT=5'b10000.
   - Write 0 -> EVT unchanged.
5. Set/clear collision: time a W1C of bit1 for the exact cycle stable_btn[1] rises -> EVT[1]=1 afterwards.
6. (INPUT_IRQ_EN) Write MASK=5'b00010, press button[1] -> irq=1 one cycle after EVT[1] sets. W1C of bit1 -> irq=0 one cycle later. Press button[0] -> irq stays 0.

Source files
------------

// File: rtl/input_port_ctrl.sv
// rtl/input_port_ctrl.sv - synchronize, debounce and expose board switches/buttons on the bridge bus
//
// Purpose: 2-flop synchronizers, tick-paced debounce of 24 switches and 5
// buttons, sticky button-press event flags (write-1-to-clear), and a
// combinational read mux for the bridge's peripheral interface.
//
// Optional feature macro: INPUT_IRQ_EN (adds the MASK register and irq output).
//
// Ports:
//   clk       peripheral clock
//   rst_n     asynchronous active-low reset
//   switches  raw switch pins (asynchronous)
//   button    raw button pins (asynchronous, high = pressed)
//   addr      word offset from the bridge, only [3:2] decoded
//   wen       one-cycle write strobe
//   wdata     write data
//   irq       (INPUT_IRQ_EN only) registered |(btn_evt & mask)
//   rdata     combinational read data selected by addr[3:2]

module input_port_ctrl #(
    parameter int TICK_CYCLES = 50000,
    parameter int DB_SAMPLES  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] switches,
    input  logic [4:0]  button,
    input  logic [11:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
`ifdef INPUT_IRQ_EN
    output logic        irq,
`endif
    output logic [31:0] rdata
);

    localparam int NB = 29;
    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [1:0] REG_SW   = 2'd0;
    localparam logic [1:0] REG_BTN  = 2'd1;
    localparam logic [1:0] REG_EVT  = 2'd2;
    localparam logic [1:0] REG_MASK = 2'd3;

    logic [NB-1:0]                   sync1_q, sync1_d;
    logic [NB-1:0]                   sync2_q, sync2_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [DB_SAMPLES-2:0][NB-1:0]   hist_q, hist_d;
    logic [NB-1:0]                   stable_q, stable_d;
    logic [4:0]                      btn_evt_q, btn_evt_d;

    logic                            tick;
    logic [NB-1:0]                   all_hi;
    logic [NB-1:0]                   all_lo;
    logic [4:0]                      btn_rise;
    logic [4:0]                      evt_clr;
    logic [1:0]                      sel;

`ifdef INPUT_IRQ_EN
    logic [4:0]                      mask_q, mask_d;
    logic                            irq_q, irq_d;
`endif

    // Address and data bits outside the decoded fields are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr[11:4], addr[1:0], wdata[31:5]};

    assign sel  = addr[3:2];
    assign tick = (cnt_q == CW'(TICK_CYCLES - 1));

    always_comb begin
        sync1_d = {button, switches};
        sync2_d = sync1_q;

        cnt_d = tick ? '0 : cnt_q + CW'(1);

        // The current sample plus the stored history forms the full window.
        all_hi = sync2_q;
        all_lo = ~sync2_q;
        for (int i = 0; i < DB_SAMPLES - 1; i++) begin
            all_hi = all_hi & hist_q[i];
            all_lo = all_lo & ~hist_q[i];
        end

        hist_d   = hist_q;
        stable_d = stable_q;
        if (tick) begin
            hist_d[0] = sync2_q;
            for (int i = 1; i < DB_SAMPLES - 1; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            stable_d = (stable_q | all_hi) & ~all_lo;
        end

        // Event sets on the same edge the debounced button rises; set beats clear.
        btn_rise  = stable_d[28:24] & ~stable_q[28:24];
        evt_clr   = (wen && (sel == REG_EVT)) ? wdata[4:0] : 5'd0;
        btn_evt_d = (btn_evt_q & ~evt_clr) | btn_rise;
    end

`ifdef INPUT_IRQ_EN
    always_comb begin
        mask_d = mask_q;
        if (wen && (sel == REG_MASK)) begin
            mask_d = wdata[4:0];
        end
        irq_d = |(btn_evt_q & mask_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            hist_q    <= '0;
            stable_q  <= '0;
            btn_evt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            hist_q    <= hist_d;
            stable_q  <= stable_d;
            btn_evt_q <= btn_evt_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (sel)
            REG_SW:   rdata = {8'd0, stable_q[23:0]};
            REG_BTN:  rdata = {27'd0, stable_q[28:24]};
            REG_EVT:  rdata = {27'd0, btn_evt_q};
`ifdef INPUT_IRQ_EN
            REG_MASK: rdata = {27'd0, mask_q};
`else
            REG_MASK: rdata = 32'd0;
`endif
            default:  rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_input_port_ctrl.sv
// tb/tb_input_port_ctrl.sv - self-checking bench for input_port_ctrl

module tb_input_port_ctrl;

    localparam int TICK = 4;
    localparam int DB   = 3;
`ifdef INPUT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] switches;
    logic [4:0]  button;
    logic [11:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
`ifdef INPUT_IRQ_EN
    logic        irq;
`endif

    input_port_ctrl #(.TICK_CYCLES(TICK), .DB_SAMPLES(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .switches (switches),
        .button   (button),
        .addr     (addr),
        .wen      (wen),
        .wdata    (wdata),
`ifdef INPUT_IRQ_EN
        .irq      (irq),
`endif
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: run-length debounce over tick samples of the raw pins
    // delayed by two edges.
    logic [28:0] m_stable;
    logic [4:0]  m_evt;
    logic [4:0]  m_mask;
    logic        m_irq;
    int          run_len [29];
    logic        run_val [29];
    logic [28:0] rawq [$];
    int          edge_n;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stable = '0;
        m_evt    = '0;
        m_mask   = '0;
        m_irq    = 1'b0;
        for (int b = 0; b < 29; b++) begin
            run_val[b] = 1'b0;
            run_len[b] = DB;
        end
        rawq.delete();
        rawq.push_back(29'd0);
        rawq.push_back(29'd0);
        edge_n = 0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [11:0] a);
        case (a[3:2])
            2'd0:    return {8'd0, m_stable[23:0]};
            2'd1:    return {27'd0, m_stable[28:24]};
            2'd2:    return {27'd0, m_evt};
            default: return IRQ_ON ? {27'd0, m_mask} : 32'd0;
        endcase
    endfunction

    task automatic cyc(input logic [23:0] sw, input logic [4:0] btn, input logic [11:0] a,
                       input logic we, input logic [31:0] wd);
        logic [28:0] s;
        logic [4:0]  old_btn;
        logic [4:0]  clr;
        logic        irq_next;
        switches = sw;
        button   = btn;
        addr     = a;
        wen      = we;
        wdata    = wd;
        #1;
        check("pre_edge_rd", rdata, exp_rd(a));
        old_btn  = m_stable[28:24];
        irq_next = |(m_evt & m_mask);
        edge_n++;
        rawq.push_back({btn, sw});
        s = rawq[rawq.size() - 3];
        void'(rawq.pop_front());
        if (edge_n % TICK == 0) begin
            for (int b = 0; b < 29; b++) begin
                if (s[b] == run_val[b]) begin
                    if (run_len[b] < DB) run_len[b]++;
                end else begin
                    run_val[b] = s[b];
                    run_len[b] = 1;
                end
                if (run_len[b] >= DB) m_stable[b] = run_val[b];
            end
        end
        clr   = (we && a[3:2] == 2'd2) ? wd[4:0] : 5'd0;
        m_evt = (m_evt & ~clr) | (m_stable[28:24] & ~old_btn);
        if (IRQ_ON && we && a[3:2] == 2'd3) m_mask = wd[4:0];
        m_irq = IRQ_ON ? irq_next : 1'b0;
        @(posedge clk);
        #1;
        check("model_rd", rdata, exp_rd(a));
`ifdef INPUT_IRQ_EN
        check("model_irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    endtask

    task automatic do_reset(input logic [23:0] sw, input logic [4:0] btn);
        @(negedge clk);
        rst_n    = 1'b0;
        switches = sw;
        button   = btn;
        wen      = 1'b0;
        wdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++) begin
            addr = 12'(a << 2);
            #1;
            check("reset_rd", rdata, 32'd0);
        end
`ifdef INPUT_IRQ_EN
        check("reset_irq", {31'd0, irq}, 32'd0);
`endif
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [23:0] sw;
        logic [4:0]  btn;
        logic [11:0] addr;
        logic        wen;
        logic [31:0] wdata;
        int          n;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] btn, input logic [11:0] a, input logic we,
                                input logic [31:0] wd, input int n, input logic [31:0] exp);
        vec_t v;
        v.sw = 24'hFFFFFF; v.btn = btn; v.addr = a; v.wen = we;
        v.wdata = wd; v.n = n; v.exp = exp;
        return v;
    endfunction

    initial begin
        vec_t tbl [$];
        int   seen;
        logic [23:0] r_sw;
        logic [4:0]  r_btn;

        // Reset release with all switches high, then button/glitch/W1C cases.
        tbl.push_back(mk(5'h00, 12'h000, 1'b0, 32'h0,        11, 32'h00000000));
        tbl.push_back(mk(5'h00, 12'h000, 1'b0, 32'h0,         1, 32'h00FFFFFF));
        tbl.push_back(mk(5'h04, 12'h004, 1'b0, 32'h0,        16, 32'h00000004));
        tbl.push_back(mk(5'h04, 12'h008, 1'b0, 32'h0,         1, 32'h00000004));
        tbl.push_back(mk(5'h00, 12'h004, 1'b0, 32'h0,        16, 32'h00000000));
        tbl.push_back(mk(5'h00, 12'h008, 1'b0, 32'h0,         1, 32'h00000004));
        tbl.push_back(mk(5'h01, 12'h004, 1'b0, 32'h0,         8, 32'h00000000));
        tbl.push_back(mk(5'h00, 12'h004, 1'b0, 32'h0,        16, 32'h00000000));
        tbl.push_back(mk(5'h00, 12'h008, 1'b0, 32'h0,         1, 32'h00000004));
        tbl.push_back(mk(5'h15, 12'h004, 1'b0, 32'h0,        16, 32'h00000015));
        tbl.push_back(mk(5'h00, 12'h004, 1'b0, 32'h0,        16, 32'h00000000));
        tbl.push_back(mk(5'h00, 12'h008, 1'b0, 32'h0,         1, 32'h00000015));
        tbl.push_back(mk(5'h00, 12'h008, 1'b1, 32'h00000005,  1, 32'h00000010));
        tbl.push_back(mk(5'h00, 12'h008, 1'b1, 32'h00000000,  1, 32'h00000010));
        tbl.push_back(mk(5'h00, 12'h000, 1'b1, 32'hFFFFFFFF,  1, 32'h00FFFFFF));
        tbl.push_back(mk(5'h00, 12'h004, 1'b1, 32'h0000001F,  1, 32'h00000000));
        tbl.push_back(mk(5'h00, 12'h008, 1'b0, 32'h0,         1, 32'h00000010));
        tbl.push_back(mk(5'h00, 12'h00C, 1'b1, 32'h0000001F,  1, IRQ_ON ? 32'h1F : 32'h0));
        tbl.push_back(mk(5'h00, 12'h00C, 1'b1, 32'h00000000,  1, 32'h00000000));
        tbl.push_back(mk(5'h00, 12'h008, 1'b1, 32'h0000001F,  1, 32'h00000000));

        rst_n = 1'b0; switches = '0; button = '0; addr = '0; wen = 1'b0; wdata = '0;
        model_reset();
        do_reset(24'hFFFFFF, 5'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            repeat (tbl[i].n) cyc(tbl[i].sw, tbl[i].btn, tbl[i].addr, tbl[i].wen, tbl[i].wdata);
            check($sformatf("vec%0d", i), rdata, tbl[i].exp);
        end

        // Continuous W1C of bit1 while button[1] is debounced: set must win once.
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(24'hFFFFFF, 5'h02, 12'h008, 1'b1, 32'h2);
            if (rdata[1]) seen++;
        end
        check("collision_set_wins", 32'(seen), 32'd1);
        cyc(24'hFFFFFF, 5'h02, 12'h004, 1'b0, 32'h0);
        check("collision_btn", rdata, 32'h2);
        repeat (16) cyc(24'hFFFFFF, 5'h00, 12'h008, 1'b0, 32'h0);
        check("collision_evt_clr", rdata, 32'h0);

`ifdef INPUT_IRQ_EN
        cyc(24'hFFFFFF, 5'h00, 12'h00C, 1'b1, 32'h2);
        seen = 0;
        for (int i = 0; i < 24 && seen == 0; i++) begin
            cyc(24'hFFFFFF, 5'h02, 12'h008, 1'b0, 32'h0);
            if (rdata[1]) seen = 1;
        end
        check("irq_evt_seen", 32'(seen), 32'd1);
        check("irq_lag", {31'd0, irq}, 32'd0);
        cyc(24'hFFFFFF, 5'h02, 12'h008, 1'b0, 32'h0);
        check("irq_assert", {31'd0, irq}, 32'd1);
        repeat (16) cyc(24'hFFFFFF, 5'h00, 12'h008, 1'b0, 32'h0);
        cyc(24'hFFFFFF, 5'h00, 12'h008, 1'b1, 32'h2);
        check("irq_hold_after_clr", {31'd0, irq}, 32'd1);
        cyc(24'hFFFFFF, 5'h00, 12'h008, 1'b0, 32'h0);
        check("irq_deassert", {31'd0, irq}, 32'd0);
        repeat (20) cyc(24'hFFFFFF, 5'h01, 12'h008, 1'b0, 32'h0);
        check("irq_masked_evt", rdata, 32'h1);
        check("irq_masked", {31'd0, irq}, 32'd0);
        cyc(24'hFFFFFF, 5'h00, 12'h00C, 1'b1, 32'h0);
        repeat (16) cyc(24'hFFFFFF, 5'h00, 12'h008, 1'b1, 32'h1F);
`endif

        // Reset mid-debounce: partial history must not shorten the next accept.
        repeat (6) cyc(24'h000000, 5'h1F, 12'h004, 1'b0, 32'h0);
        do_reset(24'h000000, 5'h1F);
        repeat (11) cyc(24'h000000, 5'h1F, 12'h004, 1'b0, 32'h0);
        check("reset_history_pre", rdata, 32'h0);
        cyc(24'h000000, 5'h1F, 12'h004, 1'b0, 32'h0);
        check("reset_history_acc", rdata, 32'h1F);

        // Randomized traffic against the model.
        r_sw  = 24'($urandom);
        r_btn = 5'($urandom);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) r_sw = 24'($urandom);
            if ($urandom_range(0, 11) == 0) r_btn = 5'($urandom);
            if (i == 700) do_reset(r_sw, r_btn);
            cyc(r_sw, r_btn, 12'($urandom), ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
